// File: rtl/vga_pkg.sv
// vga_pkg: shared 640x480@60 mode constants, counter widths and the sync
// decoder state encoding. Used by both the VGA generator and vga_sync_decoder.
package vga_pkg;

    // 640x480@60 horizontal timing, in pixel clocks
    localparam int VGA_H_VISIBLE = 640;
    localparam int VGA_H_FRONT   = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BACK    = 48;
    localparam int VGA_H_TOTAL   = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;

    // 640x480@60 vertical timing, in lines
    localparam int VGA_V_VISIBLE = 480;
    localparam int VGA_V_FRONT   = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BACK    = 33;
    localparam int VGA_V_TOTAL   = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

    // consecutive good lines needed before frame timing is checked
    localparam int VGA_LOCK_LINES = 4;

    localparam int X_W         = 10;
    localparam int Y_W         = 10;
    localparam int LINE_CNT_W  = 12;
    localparam int FRAME_CNT_W = 10;
    localparam int LOSS_CNT_W  = 8;

    typedef enum logic [1:0] {
        SEARCH,
        HLOCK,
        LOCKED
    } sync_state_t;

endpackage

// File: rtl/vga_sync_decoder_sync_edge_detect.sv
// sync_edge_detect: two-flop synchronizer for an asynchronous active-low sync
// input, plus a third flop to detect its falling edge.
//   clk      in   pixel-rate clock
//   reset_n  in   asynchronous active-low reset
//   din      in   asynchronous sync input (idle high)
//   fall     out  one-cycle pulse on synchronized 1->0 transition
// All flops reset to 1 (idle) so releasing reset never produces an edge.
module sync_edge_detect (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic fall
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign fall = s3 & ~s2;

endmodule

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: receive side of the VGA generator. Samples hsync/vsync/RGB,
// recovers pixel coordinates, measures line and frame timing and reports lock.
//
// Ports:
//   clk          in   pixel-rate clock
//   reset_n      in   asynchronous active-low reset
//   hsync/vsync  in   active-low syncs, asynchronous to clk
//   red/green/blue in 2-bit colour components
//   locked       out  line and frame timing match the configured mode
//   x, y         out  recovered position (0..H_TOTAL-1, 0..V_TOTAL-1)
//   pixel        out  {red,green,blue} aligned with x/y
//   pixel_valid  out  locked and inside the visible area
//   frame_start  out  locked and at x==0, y==0
// With VGA_SYNC_STATS_EN defined, also:
//   line_period  out  last measured line length in clocks
//   frame_lines  out  last measured lines per frame
//   lock_loss    out  saturating count of LOCKED->SEARCH transitions
//
// Pin-to-output latency is 3 clocks for pixel, x, y and the valid signals:
// two synchronizer stages plus the edge-detect / coordinate register stage.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// SEARCH | counting consecutive good lines
// HLOCK  | line timing good; first vsync arms, next vsync checks frame length
// LOCKED | line and frame timing match the mode
module vga_sync_decoder
    import vga_pkg::*;
#(
    parameter int H_VISIBLE  = VGA_H_VISIBLE,
    parameter int H_FRONT    = VGA_H_FRONT,
    parameter int H_SYNC     = VGA_H_SYNC,
    parameter int H_BACK     = VGA_H_BACK,
    parameter int V_VISIBLE  = VGA_V_VISIBLE,
    parameter int V_FRONT    = VGA_V_FRONT,
    parameter int V_SYNC     = VGA_V_SYNC,
    parameter int V_BACK     = VGA_V_BACK,
    parameter int LOCK_LINES = VGA_LOCK_LINES
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   hsync,
    input  logic                   vsync,
    input  logic [1:0]             red,
    input  logic [1:0]             green,
    input  logic [1:0]             blue,
    output logic                   locked,
    output logic [X_W-1:0]         x,
    output logic [Y_W-1:0]         y,
    output logic [5:0]             pixel,
    output logic                   pixel_valid,
    output logic                   frame_start
`ifdef VGA_SYNC_STATS_EN
    ,
    output logic [LINE_CNT_W-1:0]  line_period,
    output logic [FRAME_CNT_W-1:0] frame_lines,
    output logic [LOSS_CNT_W-1:0]  lock_loss
`endif
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int GOOD_W  = $clog2(LOCK_LINES + 1);

    localparam logic [X_W-1:0]         X_LAST     = X_W'(H_TOTAL - 1);
    localparam logic [X_W-1:0]         X_LOAD     = X_W'(H_VISIBLE + H_FRONT);
    localparam logic [X_W-1:0]         X_VIS      = X_W'(H_VISIBLE);
    localparam logic [Y_W-1:0]         Y_LAST     = Y_W'(V_TOTAL - 1);
    localparam logic [Y_W-1:0]         Y_LOAD     = Y_W'(V_VISIBLE + V_FRONT);
    localparam logic [Y_W-1:0]         Y_VIS      = Y_W'(V_VISIBLE);
    // cnt_line holds clocks-since-edge minus one at the next edge
    localparam logic [LINE_CNT_W-1:0]  LINE_GOOD  = LINE_CNT_W'(H_TOTAL - 1);
    localparam logic [LINE_CNT_W-1:0]  LINE_TMO   = LINE_CNT_W'(2 * H_TOTAL);
    localparam logic [FRAME_CNT_W-1:0] FRAME_GOOD = FRAME_CNT_W'(V_TOTAL);
    localparam logic [GOOD_W-1:0]      GOOD_LAST  = GOOD_W'(LOCK_LINES - 1);

    logic                   hs_fall;
    logic                   vs_fall;
    logic [5:0]             rgb_s1;
    logic [5:0]             rgb_s2;
    logic [LINE_CNT_W-1:0]  cnt_line;
    logic [FRAME_CNT_W-1:0] cnt_frame;
    logic                   good_line;
    logic                   good_frame;
    logic                   timeout;
    logic                   bad_line;
    sync_state_t            state;
    sync_state_t            state_nxt;
    logic [GOOD_W-1:0]      good_cnt;
    logic [GOOD_W-1:0]      good_cnt_nxt;
    logic                   armed;
    logic                   armed_nxt;

    sync_edge_detect u_hs_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (hsync),
        .fall    (hs_fall)
    );

    sync_edge_detect u_vs_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (vsync),
        .fall    (vs_fall)
    );

    // RGB takes three stages so it lines up with x/y, which update from the
    // edge-detect stage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rgb_s1 <= '0;
            rgb_s2 <= '0;
            pixel  <= '0;
        end else begin
            rgb_s1 <= {red, green, blue};
            rgb_s2 <= rgb_s1;
            pixel  <= rgb_s2;
        end
    end

    // hsync falls at the start of the sync pulse, i.e. x = visible + front porch
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x <= '0;
        end else if (hs_fall) begin
            x <= X_LOAD;
        end else if (x == X_LAST) begin
            x <= '0;
        end else begin
            x <= x + X_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            y <= '0;
        end else if (vs_fall) begin
            y <= Y_LOAD;
        end else if (x == X_LAST && !hs_fall) begin
            y <= (y == Y_LAST) ? '0 : y + Y_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_line <= '0;
        end else if (hs_fall) begin
            cnt_line <= '0;
        end else if (cnt_line != '1) begin
            cnt_line <= cnt_line + LINE_CNT_W'(1);
        end
    end

    // A line edge coinciding with the frame edge belongs to the new frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_frame <= '0;
        end else if (vs_fall) begin
            cnt_frame <= hs_fall ? FRAME_CNT_W'(1) : '0;
        end else if (hs_fall && cnt_frame != '1) begin
            cnt_frame <= cnt_frame + FRAME_CNT_W'(1);
        end
    end

    assign good_line  = (cnt_line == LINE_GOOD);
    assign good_frame = (cnt_frame == FRAME_GOOD);
    // cnt_line saturates past the threshold, so this fires once per dropout
    assign timeout    = !hs_fall && (cnt_line == LINE_TMO);
    assign bad_line   = hs_fall && !good_line;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= SEARCH;
            good_cnt <= '0;
            armed    <= 1'b0;
        end else begin
            state    <= state_nxt;
            good_cnt <= good_cnt_nxt;
            armed    <= armed_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        good_cnt_nxt = good_cnt;
        armed_nxt    = armed;
        case (state)
            SEARCH: begin
                armed_nxt = 1'b0;
                if (timeout || bad_line) begin
                    good_cnt_nxt = '0;
                end else if (hs_fall) begin
                    if (good_cnt == GOOD_LAST) begin
                        state_nxt    = HLOCK;
                        good_cnt_nxt = '0;
                    end else begin
                        good_cnt_nxt = good_cnt + GOOD_W'(1);
                    end
                end
            end
            HLOCK: begin
                if (timeout || bad_line) begin
                    state_nxt = SEARCH;
                    armed_nxt = 1'b0;
                end else if (vs_fall) begin
                    if (!armed) begin
                        armed_nxt = 1'b1;
                    end else begin
                        state_nxt = good_frame ? LOCKED : SEARCH;
                        armed_nxt = 1'b0;
                    end
                end
            end
            LOCKED: begin
                if (timeout || bad_line || (vs_fall && !good_frame)) begin
                    state_nxt = SEARCH;
                end
            end
            default: begin
                state_nxt    = SEARCH;
                good_cnt_nxt = '0;
                armed_nxt    = 1'b0;
            end
        endcase
    end

    assign locked      = (state == LOCKED);
    assign pixel_valid = locked && (x < X_VIS) && (y < Y_VIS);
    assign frame_start = locked && (x == '0) && (y == '0);

`ifdef VGA_SYNC_STATS_EN
    logic lock_lost;

    assign lock_lost = (state == LOCKED) && (state_nxt == SEARCH);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            line_period <= '0;
            frame_lines <= '0;
            lock_loss   <= '0;
        end else begin
            if (hs_fall) begin
                line_period <= (cnt_line == '1) ? cnt_line : cnt_line + LINE_CNT_W'(1);
            end
            if (vs_fall) begin
                frame_lines <= cnt_frame;
            end
            if (lock_lost && lock_loss != '1) begin
                lock_loss <= lock_loss + LOSS_CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder. A full-size instance checks the 640x480 load
// and wrap points; a reduced-mode instance (32x20 total) runs the lock,
// loss and relock sequences so whole frames stay short.
module tb_vga_sync_decoder;
    import vga_pkg::*;

    logic clk = 1'b0;
    always #20 clk = ~clk;

    logic       reset_n;
    logic       hsync, vsync;
    logic [1:0] red, green, blue;
    logic       locked;
    logic [9:0] x, y;
    logic [5:0] pixel;
    logic       pixel_valid, frame_start;

    logic       hsync_f, vsync_f;
    logic [1:0] zero2;
    logic       locked_f;
    logic [9:0] x_f, y_f;
    logic [5:0] pixel_f;
    logic       pv_f, fs_f;

`ifdef VGA_SYNC_STATS_EN
    logic [11:0] line_period, line_period_f;
    logic [9:0]  frame_lines, frame_lines_f;
    logic [7:0]  lock_loss, lock_loss_f;
`endif

    vga_sync_decoder #(
        .H_VISIBLE(16), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
        .V_VISIBLE(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(4),
        .LOCK_LINES(4)
    ) dut (
        .clk(clk), .reset_n(reset_n), .hsync(hsync), .vsync(vsync),
        .red(red), .green(green), .blue(blue),
        .locked(locked), .x(x), .y(y), .pixel(pixel),
        .pixel_valid(pixel_valid), .frame_start(frame_start)
`ifdef VGA_SYNC_STATS_EN
        , .line_period(line_period), .frame_lines(frame_lines), .lock_loss(lock_loss)
`endif
    );

    vga_sync_decoder dut_full (
        .clk(clk), .reset_n(reset_n), .hsync(hsync_f), .vsync(vsync_f),
        .red(zero2), .green(zero2), .blue(zero2),
        .locked(locked_f), .x(x_f), .y(y_f), .pixel(pixel_f),
        .pixel_valid(pv_f), .frame_start(fs_f)
`ifdef VGA_SYNC_STATS_EN
        , .line_period(line_period_f), .frame_lines(frame_lines_f), .lock_loss(lock_loss_f)
`endif
    );

    typedef struct {
        int x;
        int y;
        int f;
    } pos_t;

    typedef struct {
        int tx;
        int ty;
        int ex;
        int ey;
        int epix;
        int evalid;
        int efs;
    } vec_t;

    int   errors = 0;
    int   checks = 0;
    int   gx, gy, gf;
    bit   gen_en;
    int   sl_y, sl_f, sf_f, hold_f, hold_y;
    bit   coinc;
    pos_t hist[4];
    vec_t vecs[7];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (gen pos %0d,%0d frame %0d, t=%0t)",
                     name, act, exp, hist[3].x, hist[3].y, hist[3].f, $time);
        end
    endtask

    // small-mode generator: 32 clocks/line, hsync low 20..27; 20 lines, vsync low on 14..15
    task automatic drive_pins();
        int p;
        logic [5:0] c;
        if (!gen_en) begin
            hsync = 1'b1;
            vsync = 1'b1;
            {red, green, blue} = 6'd0;
        end else begin
            hsync = !(gx >= 20 && gx < 28);
            if (hold_f >= 0 && (gf > hold_f || (gf == hold_f && gy >= hold_y)))
                hsync = 1'b1;
            p = gy * 32 + gx;
            if (coinc)
                vsync = !(p >= 14 * 32 + 20 && p < 16 * 32 + 20);
            else
                vsync = !(gy >= 14 && gy < 16);
            c = 6'(gx);
            {red, green, blue} = c;
        end
    endtask

    task automatic advance();
        int llen, flen;
        llen = (gy == sl_y && gf == sl_f) ? 31 : 32;
        flen = (gf == sf_f) ? 19 : 20;
        if (gx == llen - 1) begin
            gx = 0;
            if (gy == flen - 1) begin
                gy = 0;
                gf++;
            end else begin
                gy++;
            end
        end else begin
            gx++;
        end
    endtask

    task automatic push_hist();
        for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
        if (gen_en) hist[0] = '{gx, gy, gf};
        else        hist[0] = '{-1, -1, -1};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (gen_en) advance();
        drive_pins();
        push_hist();
    endtask

    // runs until the DUT output stage shows generator position (x,y) of frame f
    task automatic run_until(input int f, input int px, input int py);
        int n;
        n = 0;
        while (!(hist[3].x == px && hist[3].y == py && hist[3].f == f) && n < 5000) begin
            step();
            n++;
        end
        chk("reach_position", (n < 5000) ? 1 : 0, 1);
    endtask

    task automatic do_reset(input int sx, input int sy);
        reset_n = 1'b0;
        gen_en  = 1'b0;
        drive_pins();
        for (int i = 0; i < 3; i++) step();
        gx = sx;
        gy = sy;
        gf = 0;
        gen_en = 1'b1;
        for (int i = 0; i < 4; i++) hist[i] = '{-1, -1, -1};
        drive_pins();
        push_hist();
        reset_n = 1'b1;
    endtask

    task automatic check_lock(input int f, input int px, input int py, input string name);
        run_until(f, px, py);
        chk({name, "_before"}, int'(locked), 0);
        step();
        chk({name, "_after"}, int'(locked), 1);
    endtask

    initial begin
        #(40 * 60000);
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        vecs[0] = '{tx:0,  ty:0,  ex:0,  ey:0,  epix:0,  evalid:1, efs:1};
        vecs[1] = '{tx:1,  ty:0,  ex:1,  ey:0,  epix:1,  evalid:1, efs:0};
        vecs[2] = '{tx:15, ty:11, ex:15, ey:11, epix:15, evalid:1, efs:0};
        vecs[3] = '{tx:16, ty:11, ex:16, ey:11, epix:16, evalid:0, efs:0};
        vecs[4] = '{tx:31, ty:11, ex:31, ey:11, epix:31, evalid:0, efs:0};
        vecs[5] = '{tx:0,  ty:12, ex:0,  ey:12, epix:0,  evalid:0, efs:0};
        vecs[6] = '{tx:31, ty:19, ex:31, ey:19, epix:31, evalid:0, efs:0};

        sl_y = -1; sl_f = -1; sf_f = -1; hold_f = -1; hold_y = -1; coinc = 1'b0;
        gx = 0; gy = 0; gf = 0; gen_en = 1'b0;
        for (int i = 0; i < 4; i++) hist[i] = '{-1, -1, -1};
        zero2   = 2'b00;
        hsync_f = 1'b1;
        vsync_f = 1'b1;
        reset_n = 1'b0;
        drive_pins();
        step();
        step();

        // reset state
        chk("rst_locked", int'(locked), 0);
        chk("rst_x", int'(x), 0);
        chk("rst_y", int'(y), 0);
        chk("rst_pixel", int'(pixel), 0);
        chk("rst_pixel_valid", int'(pixel_valid), 0);
        chk("rst_frame_start", int'(frame_start), 0);
        chk("rst_full_x", int'(x_f), 0);
        chk("rst_full_y", int'(y_f), 0);
        chk("rst_full_outs", int'({locked_f, pixel_f, pv_f, fs_f}), 0);
`ifdef VGA_SYNC_STATS_EN
        chk("rst_line_period", int'(line_period), 0);
        chk("rst_frame_lines", int'(frame_lines), 0);
        chk("rst_lock_loss", int'(lock_loss), 0);
        chk("rst_full_stats", int'({line_period_f, frame_lines_f, lock_loss_f}), 0);
`endif

        // full-size mode: hsync fall loads 656, wraps 799 -> 0 and bumps y
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) step();
        hsync_f = 1'b0;
        for (int i = 1; i <= 147; i++) begin
            step();
            if (i == 96) hsync_f = 1'b1;
            if (i == 3)   chk("full_x_load", int'(x_f), 656);
            if (i == 146) chk("full_x_last", int'(x_f), 799);
            if (i == 147) begin
                chk("full_x_wrap", int'(x_f), 0);
                chk("full_y_inc", int'(y_f), 1);
            end
        end

        // clean stream: 4 good lines, arming vsync, then lock on the next good frame
        do_reset(0, 0);
        run_until(0, 0, 14);
        chk("t1_armed_not_locked", int'(locked), 0);
        check_lock(1, 31, 13, "t1_lock");
`ifdef VGA_SYNC_STATS_EN
        chk("t1_line_period", int'(line_period), 32);
        chk("t1_frame_lines", int'(frame_lines), 20);
        chk("t1_lock_loss", int'(lock_loss), 0);
`endif
        for (int i = 0; i < 7; i++) begin
            run_until(2, vecs[i].tx, vecs[i].ty);
            chk("vec_x", int'(x), vecs[i].ex);
            chk("vec_y", int'(y), vecs[i].ey);
            chk("vec_pixel", int'(pixel), vecs[i].epix);
            chk("vec_pixel_valid", int'(pixel_valid), vecs[i].evalid);
            chk("vec_frame_start", int'(frame_start), vecs[i].efs);
            chk("vec_locked", int'(locked), 1);
        end

        // one short line (31 clocks) on line 5 of frame 3
        sl_f = 3;
        sl_y = 5;
        run_until(3, 19, 6);
        chk("t2_still_locked", int'(locked), 1);
        step();
        chk("t2_drop", int'(locked), 0);
        run_until(3, 0, 14);
        chk("t2_armed_not_locked", int'(locked), 0);
        check_lock(4, 31, 13, "t2_relock");
`ifdef VGA_SYNC_STATS_EN
        chk("t2_lock_loss", int'(lock_loss), 1);
`endif

        // hsync held high from line 3 of frame 5: timeout 64 clocks after last edge
        hold_f = 5;
        hold_y = 3;
        run_until(5, 20, 4);
        chk("t3_before_timeout", int'(locked), 1);
        step();
        chk("t3_timeout_drop", int'(locked), 0);
        chk("t3_x_runs", int'(x), 21);
        chk("t3_y_runs", int'(y), 4);
        run_until(5, 0, 5);
        chk("t3_x_wrap", int'(x), 0);
        chk("t3_y_wrap", int'(y), 5);
`ifdef VGA_SYNC_STATS_EN
        chk("t3_lock_loss", int'(lock_loss), 2);
`endif
        hold_f = -1;
        sl_f   = -1;

        // frame 2 has only 19 lines: lock falls at the vsync that closes it
        sf_f = 2;
        do_reset(0, 0);
        check_lock(1, 31, 13, "t4_lock");
        run_until(3, 31, 13);
        chk("t4_still_locked", int'(locked), 1);
`ifdef VGA_SYNC_STATS_EN
        chk("t4_loss_before", int'(lock_loss), 0);
`endif
        step();
        chk("t4_bad_frame_drop", int'(locked), 0);
`ifdef VGA_SYNC_STATS_EN
        chk("t4_frame_lines", int'(frame_lines), 19);
        chk("t4_loss_after", int'(lock_loss), 1);
`endif
        sf_f = -1;

        // asynchronous reset mid-frame, then relock
        do_reset(0, 0);
        check_lock(1, 31, 13, "t5_lock");
        run_until(2, 10, 5);
        #3;
        reset_n = 1'b0;
        #1;
        chk("t5_async_locked", int'(locked), 0);
        chk("t5_async_x", int'(x), 0);
        chk("t5_async_y", int'(y), 0);
        chk("t5_async_pixel", int'(pixel), 0);
        chk("t5_async_pixel_valid", int'(pixel_valid), 0);
        chk("t5_async_frame_start", int'(frame_start), 0);
`ifdef VGA_SYNC_STATS_EN
        chk("t5_async_stats", int'({line_period, frame_lines, lock_loss}), 0);
`endif
        step();
        step();
        reset_n = 1'b1;
        step();
        step();
        step();
        chk("t5_no_false_edge_x", int'(x), 3);
        chk("t5_release_y", int'(y), 0);
        chk("t5_release_locked", int'(locked), 0);
        check_lock(3, 31, 13, "t5_relock");

        // vsync falls together with hsync
        coinc = 1'b1;
        do_reset(0, 5);
        run_until(0, 20, 14);
        chk("t6_x_load", int'(x), 20);
        chk("t6_y_load", int'(y), 14);
        chk("t6_not_locked", int'(locked), 0);
        check_lock(1, 19, 14, "t6_lock");
        run_until(2, 21, 14);
        chk("t6_frame_stays_good", int'(locked), 1);
`ifdef VGA_SYNC_STATS_EN
        chk("t6_frame_lines", int'(frame_lines), 20);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
